stepper_ramp_controller: RTL

//  Trapezoidal motion sequencer for bipolar_micro_stepper. Takes one move command
//  (distance, direction, speed limits) and drives the stepper's go/stop and period inputs.

---
 rtl/stepper_ramp_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stepper_ramp_controller.sv
// rtl/stepper_ramp_controller.sv - trapezoidal period sequencer driving bipolar_micro_stepper
// Optional watchdog: define STEPPER_RAMP_WATCHDOG_EN (otherwise o_fault is tied 0).
module stepper_ramp_controller #(
  parameter int STEP_W   = 24,
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_direction,
  input  logic [STEP_W-1:0]   i_target_steps,
  input  logic [PERIOD_W-1:0] i_start_period,
  input  logic [PERIOD_W-1:0] i_min_period,
  input  logic [PERIOD_W-1:0] i_period_delta,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_fault,
  output logic                o_stp_go,
  output logic                o_stp_stop,
  output logic                o_stp_direction,
  output logic [31:0]         o_stp_steps,
  output logic [PERIOD_W-1:0] o_stp_period,
  input  logic                i_stp_busy,
  input  logic [31:0]         i_stp_step_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_ACCEL, S_CRUISE, S_DECEL, S_DRAIN, S_DONE
  } state_t;

  state_t              r_state, w_state_n;
  logic                r_dir;
  logic [STEP_W-1:0]   r_target;
  logic [PERIOD_W-1:0] r_start_p, r_min_p, r_delta, r_period;
  logic [31:0]         r_base, r_last_cnt, r_n_acc;
  logic                r_go, r_stop, r_done;

  logic [PERIOD_W-1:0] w_period_n, w_dec, w_inc, w_min_clamp;
  logic [31:0]         w_n_acc_n, w_n_acc_inc, w_done_cnt, w_target32, w_rem;
  logic                w_go_n, w_stop_n, w_done_n, w_accept, w_fault_set;
  logic                w_step, w_reached, w_wdog_trip;

  assign w_done_cnt  = i_stp_step_count - r_base;
  assign w_target32  = 32'(r_target);
  assign w_reached   = (w_done_cnt >= w_target32);
  assign w_rem       = w_reached ? 32'd0 : (w_target32 - w_done_cnt);
  assign w_step      = (i_stp_step_count != r_last_cnt);
  assign w_n_acc_inc = r_n_acc + 32'd1;
  assign w_min_clamp = (i_min_period > i_start_period) ? i_start_period : i_min_period;
  // r_period always stays within [r_min_p, r_start_p], so these differences cannot wrap
  assign w_dec = ((r_period - r_min_p) > r_delta) ? (r_period - r_delta) : r_min_p;
  assign w_inc = ((r_start_p - r_period) > r_delta) ? (r_period + r_delta) : r_start_p;

`ifdef STEPPER_RAMP_WATCHDOG_EN
  logic [PERIOD_W+2:0] r_wdog;
  logic                r_fault;
  logic                w_ramp_state;

  assign w_ramp_state = (r_state == S_ACCEL) || (r_state == S_CRUISE) || (r_state == S_DECEL);
  assign w_wdog_trip  = (r_wdog > {1'b0, r_start_p, 2'b00});
  assign o_fault      = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_wdog <= (w_ramp_state && !w_step) ? r_wdog + 1'b1 : '0;
      if (r_state == S_IDLE && i_start && !i_abort) r_fault <= 1'b0;
      else if (w_fault_set)                         r_fault <= 1'b1;
    end
  end
`else
  assign w_wdog_trip = 1'b0;
  assign o_fault     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    w_period_n  = r_period;
    w_n_acc_n   = r_n_acc;
    w_go_n      = r_go;
    w_stop_n    = 1'b0;
    w_done_n    = 1'b0;
    w_accept    = 1'b0;
    w_fault_set = 1'b0;
    if (r_state != S_IDLE && r_state != S_DONE && (i_abort || w_wdog_trip)) begin
      w_stop_n    = 1'b1;
      w_go_n      = 1'b0;
      w_fault_set = w_wdog_trip;
      w_state_n   = S_DONE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            if (i_target_steps == '0) begin
              w_done_n = 1'b1;
            end else begin
              w_accept   = 1'b1;
              w_period_n = i_start_period;
              w_n_acc_n  = 32'd0;
              w_state_n  = S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          w_go_n    = 1'b1;
          w_state_n = S_ACCEL;
        end
        S_ACCEL: begin
          // Odd move: middle step holds the peak; even move: turn right after the last decrement
          if (w_step) begin
            if (w_rem <= r_n_acc) begin
              w_state_n = S_DECEL;
            end else begin
              w_n_acc_n  = w_n_acc_inc;
              w_period_n = w_dec;
              if (w_rem <= w_n_acc_inc)  w_state_n = S_DECEL;
              else if (w_dec == r_min_p) w_state_n = S_CRUISE;
            end
          end else if (r_period == r_min_p) begin
            w_state_n = S_CRUISE;
          end
        end
        S_CRUISE: begin
          if (w_step && (w_rem <= r_n_acc)) w_state_n = S_DECEL;
        end
        S_DECEL: begin
          if (w_step)           w_period_n = w_inc;
          if (w_rem == 32'd0)   w_state_n  = S_DRAIN;
        end
        S_DRAIN: begin
          if (w_reached) begin
            w_go_n    = 1'b0;
            w_state_n = S_DONE;
          end
        end
        S_DONE: begin
          if (!i_stp_busy) begin
            w_done_n  = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dir      <= 1'b0;
      r_target   <= '0;
      r_start_p  <= '0;
      r_min_p    <= '0;
      r_delta    <= '0;
      r_period   <= '0;
      r_base     <= '0;
      r_last_cnt <= '0;
      r_n_acc    <= '0;
      r_go       <= 1'b0;
      r_stop     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_period   <= w_period_n;
      r_n_acc    <= w_n_acc_n;
      r_go       <= w_go_n;
      r_stop     <= w_stop_n;
      r_done     <= w_done_n;
      r_last_cnt <= i_stp_step_count;
      if (w_accept) begin
        r_dir     <= i_direction;
        r_target  <= i_target_steps;
        r_start_p <= i_start_period;
        r_min_p   <= w_min_clamp;
        r_delta   <= i_period_delta;
      end
      if (r_state == S_LAUNCH) r_base <= i_stp_step_count;
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_done          = r_done;
  assign o_stp_go        = r_go;
  assign o_stp_stop      = r_stop;
  assign o_stp_direction = r_dir;
  assign o_stp_steps     = {r_target, 8'h00};
  assign o_stp_period    = r_period;

endmodule
